// File: rtl/hilo_div_pkg.sv
// Shared types, constants and helpers for the HI/LO divide unit.
// The optional zero-divisor flag is enabled with HILO_DIV_ZERO_FLAG_EN.
package hilo_div_pkg;

  localparam int DIV_WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

  localparam logic [DIV_WIDTH_DEFAULT-1:0] ALL_ONES = '1;
  localparam logic [DIV_WIDTH_DEFAULT-1:0] INT_MIN  = {1'b1, {(DIV_WIDTH_DEFAULT-1){1'b0}}};

  // Magnitude of x when treated as signed; INT_MIN maps to itself, which is the correct unsigned magnitude.
  function automatic logic [DIV_WIDTH_DEFAULT-1:0] abs_w(
    input logic [DIV_WIDTH_DEFAULT-1:0] x,
    input logic                         sgn
  );
    return (sgn && x[DIV_WIDTH_DEFAULT-1]) ? (~x + 1'b1) : x;
  endfunction

endpackage

// File: rtl/hilo_div_step.sv
// One restoring-division step: shift {rem,quo} left, subtract the divisor on a trial basis.
// Purely combinational.
module hilo_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] trial;

  always_comb begin
    rem_sh = {rem_i, quo_i[WIDTH-1]};
    trial  = rem_sh - {1'b0, divisor_i};
    // Partial remainder stays below the divisor, so WIDTH+1 bits cannot wrap.
    rem_o  = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_o  = {quo_i[WIDTH-2:0], ~trial[WIDTH]};
  end

endmodule

// File: rtl/hilo_div_unit.sv
// Iterative DIV/DIVU unit owning the HI/LO pair; quotient lands in LO, remainder in HI.
// Define HILO_DIV_ZERO_FLAG_EN for the dz output and a short-cut path on divide by zero.
module hilo_div_unit
  import hilo_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             mthi_we,
  input  logic             mtlo_we,
  input  logic [WIDTH-1:0] mt_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
`ifdef HILO_DIV_ZERO_FLAG_EN
  ,
  output logic             dz
`endif
);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q, quo_q, dvsr_q, dvnd_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             q_neg_q, r_neg_q, dz_q, ovf_q;
  logic             busy_q, done_q;
  logic [WIDTH-1:0] rem_d, quo_d, hi_d, lo_d;
  logic             div_zero, div_ovf;

  hilo_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvsr_q),
    .rem_o     (rem_d),
    .quo_o     (quo_d)
  );

  always_comb begin
    div_zero = (divisor == '0);
    div_ovf  = is_signed && (dividend == INT_MIN) && (divisor == ALL_ONES);
    hi_d     = r_neg_q ? (~rem_q + 1'b1) : rem_q;
    lo_d     = q_neg_q ? (~quo_q + 1'b1) : quo_q;
    // Architected results for the two corner cases override the iterative datapath.
    if (dz_q) begin
      lo_d = ALL_ONES;
      hi_d = dvnd_q;
    end else if (ovf_q) begin
      lo_d = INT_MIN;
      hi_d = '0;
    end
  end

`ifdef HILO_DIV_ZERO_FLAG_EN
  logic dz_out_q;
  assign dz = dz_out_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      dvnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef HILO_DIV_ZERO_FLAG_EN
      dz_out_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef HILO_DIV_ZERO_FLAG_EN
      dz_out_q <= 1'b0;
`endif
      if (!busy_q) begin
        if (mthi_we) hi_q <= mt_data;
        if (mtlo_we) lo_q <= mt_data;
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            rem_q   <= '0;
            quo_q   <= abs_w(dividend, is_signed);
            dvsr_q  <= abs_w(divisor, is_signed);
            dvnd_q  <= dividend;
            q_neg_q <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_neg_q <= is_signed && dividend[WIDTH-1];
            dz_q    <= div_zero;
            ovf_q   <= div_ovf;
            cnt_q   <= CNT_W'(WIDTH);
            busy_q  <= 1'b1;
`ifdef HILO_DIV_ZERO_FLAG_EN
            state_q <= div_zero ? FIX : RUN;
`else
            state_q <= RUN;
`endif
          end
        end
        RUN: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_q <= FIX;
        end
        FIX: begin
          hi_q    <= hi_d;
          lo_q    <= lo_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
          state_q <= IDLE;
`ifdef HILO_DIV_ZERO_FLAG_EN
          dz_out_q <= dz_q;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_hilo_div_unit.sv
// Scoreboard bench for hilo_div_unit: divides, HI/LO moves, ignored starts and mid-divide reset.
module tb_hilo_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        mthi_we;
  logic        mtlo_we;
  logic [31:0] mt_data;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        dz_sig;

  always #5 clk = ~clk;

  hilo_div_unit dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .mthi_we   (mthi_we),
    .mtlo_we   (mtlo_we),
    .mt_data   (mt_data),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
`ifdef HILO_DIV_ZERO_FLAG_EN
    ,
    .dz        (dz_sig)
`endif
  );

`ifndef HILO_DIV_ZERO_FLAG_EN
  assign dz_sig = 1'b0;
`endif

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
    logic        dz;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic exp_t model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.dz  = 1'b0;
    e.lat = 34;
    if (b == 32'd0) begin
      e.lo = 32'hFFFF_FFFF;
      e.hi = a;
      e.dz = 1'b1;
`ifdef HILO_DIV_ZERO_FLAG_EN
      e.lat = 2;
`endif
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.lo = 32'h8000_0000;
      e.hi = 32'd0;
    end else if (sgn) begin
      e.lo = $signed(a) / $signed(b);
      e.hi = $signed(a) % $signed(b);
    end else begin
      e.lo = a / b;
      e.hi = a % b;
    end
    return e;
  endfunction

  // Launches at the current negedge (cycle 0), waits for done, then checks against the scoreboard.
  task automatic test_one_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   got;
    int   busy_cnt;
    sb.push_back(model(sgn, a, b));
    start = 1'b1; is_signed = sgn; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0;
    got = -1;
    busy_cnt = 0;
    for (int k = 1; k <= 100; k++) begin
      if (done) begin
        got = k;
        break;
      end
      if (busy) busy_cnt++;
      @(negedge clk);
    end
    e = sb.pop_front();
    total++;
    if (got !== e.lat) begin
      bad++; $display("FAIL div_latency a=%h b=%h got=%0d exp=%0d", a, b, got, e.lat);
    end
    total++;
    if (busy_cnt !== e.lat - 1) begin
      bad++; $display("FAIL div_busy_cycles a=%h b=%h got=%0d exp=%0d", a, b, busy_cnt, e.lat - 1);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL div_busy_at_done a=%h b=%h got=%b exp=0", a, b, busy);
    end
    total++;
    if (lo !== e.lo) begin
      bad++; $display("FAIL div_lo sgn=%0d a=%h b=%h got=%h exp=%h", sgn, a, b, lo, e.lo);
    end
    total++;
    if (hi !== e.hi) begin
      bad++; $display("FAIL div_hi sgn=%0d a=%h b=%h got=%h exp=%h", sgn, a, b, hi, e.hi);
    end
`ifdef HILO_DIV_ZERO_FLAG_EN
    total++;
    if (dz_sig !== e.dz) begin
      bad++; $display("FAIL div_dz a=%h b=%h got=%b exp=%b", a, b, dz_sig, e.dz);
    end
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, done, dz_sig} !== 3'b000) begin
      bad++; $display("FAIL reset_flags got=%b exp=000", {busy, done, dz_sig});
    end
    total++;
    if (hi !== 32'd0 || lo !== 32'd0) begin
      bad++; $display("FAIL reset_hilo got=%h/%h exp=0/0", hi, lo);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_arith();
    test_one_div(1'b1, 32'd1, 32'd5);
    test_one_div(1'b1, 32'hFFFF_FFF9, 32'h0000_0002);
    test_one_div(1'b0, 32'hFFFF_FFFF, 32'h0000_0010);
    test_one_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    test_one_div(1'b0, 32'd100, 32'd0);
    test_one_div(1'b1, 32'hFFFF_FF00, 32'd0);
    test_one_div(1'b1, 32'd7, 32'hFFFF_FFFE);
    test_one_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    for (int i = 0; i < 4; i++)
      test_one_div(i[0], $urandom, $urandom_range(1, 1 << (8 * (i + 1) - 1)));
  endtask

  // test_one_div returns in the done cycle, so each call here starts in the previous done cycle.
  task automatic test_back_to_back();
    test_one_div(1'b0, 32'd1000, 32'd7);
    test_one_div(1'b1, 32'hFFFF_F000, 32'd9);
    test_one_div(1'b0, 32'd55, 32'd56);
  endtask

  task automatic test_mt();
    exp_t e;
    int   got;
    mthi_we = 1'b1; mtlo_we = 1'b1; mt_data = 32'hA5A5_0001;
    @(negedge clk);
    mthi_we = 1'b0; mtlo_we = 1'b0;
    total++;
    if (hi !== 32'hA5A5_0001 || lo !== 32'hA5A5_0001) begin
      bad++; $display("FAIL mt_both got=%h/%h exp=a5a50001/a5a50001", hi, lo);
    end
    sb.push_back(model(1'b0, 32'd1000, 32'd3));
    start = 1'b1; is_signed = 1'b0; dividend = 32'd1000; divisor = 32'd3;
    mthi_we = 1'b1; mt_data = 32'h0BAD_F00D;
    @(negedge clk);
    start = 1'b0; mthi_we = 1'b0;
    total++;
    if (hi !== 32'h0BAD_F00D) begin
      bad++; $display("FAIL mt_with_start got=%h exp=0badf00d", hi);
    end
    got = -1;
    for (int k = 1; k <= 100; k++) begin
      if (done) begin
        got = k;
        break;
      end
      @(negedge clk);
    end
    e = sb.pop_front();
    total++;
    if (got !== e.lat || hi !== e.hi || lo !== e.lo) begin
      bad++; $display("FAIL mt_overwrite lat=%0d hi=%h lo=%h exp lat=%0d hi=%h lo=%h", got, hi, lo, e.lat, e.hi, e.lo);
    end
  endtask

  task automatic test_sequence();
    exp_t e;
    int   early = 0;
    int   extra = 0;
    sb.push_back(model(1'b1, 32'd100, 32'd7));
    for (int k = 0; k <= 34; k++) begin
      start     = (k == 0) || (k == 5);
      is_signed = 1'b1;
      dividend  = (k == 5) ? 32'd999 : 32'd100;
      divisor   = (k == 5) ? 32'd3 : 32'd7;
      mthi_we   = (k == 10);
      mt_data   = 32'hDEAD_BEEF;
      if (k >= 1 && k < 34 && done) early++;
      if (k == 34) begin
        e = sb.pop_front();
        total++;
        if (done !== 1'b1) begin
          bad++; $display("FAIL seq_done_c34 got=%b exp=1", done);
        end
        total++;
        if (hi !== e.hi || lo !== e.lo) begin
          bad++; $display("FAIL seq_hilo got=%h/%h exp=%h/%h", hi, lo, e.hi, e.lo);
        end
      end
      @(negedge clk);
    end
    start = 1'b0; mthi_we = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (done || busy) extra++;
      @(negedge clk);
    end
    total++;
    if (early !== 0 || extra !== 0) begin
      bad++; $display("FAIL seq_ignored_start early=%0d extra=%0d exp=0/0", early, extra);
    end
    mtlo_we = 1'b1; mt_data = 32'h0000_1234;
    @(negedge clk);
    mtlo_we = 1'b0;
    total++;
    if (lo !== 32'h0000_1234 || hi !== e.hi) begin
      bad++; $display("FAIL seq_mtlo got=%h/%h exp=%h/00001234", hi, lo, e.hi);
    end
  endtask

  task automatic test_reset_mid();
    int early = 0;
    for (int k = 0; k <= 10; k++) begin
      start = (k == 0); is_signed = 1'b0; dividend = 32'd12345; divisor = 32'd11;
      rst   = (k == 10);
      if (k >= 1 && done) early++;
      @(negedge clk);
    end
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || early !== 0) begin
      bad++; $display("FAIL rst_mid_flags busy=%b done=%b early=%0d exp=0/0/0", busy, done, early);
    end
    total++;
    if (hi !== 32'd0 || lo !== 32'd0) begin
      bad++; $display("FAIL rst_mid_hilo got=%h/%h exp=0/0", hi, lo);
    end
    rst = 1'b0;
    test_one_div(1'b1, 32'hFFFF_FF9C, 32'd7);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    mthi_we = 1'b0; mtlo_we = 1'b0; mt_data = '0;
    @(negedge clk);
    test_reset();
    test_arith();
    test_back_to_back();
    test_mt();
    test_sequence();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
